mskaes_inv_rcon_seq: RTL and testbench
======================================

// Module: mskaes_inv_rcon_seq
// PURPOSE
//  Masked AES-128 inverse round-constant sequencer for the decryption key schedule.
//  Walks rcon backward from 0x36 to 0x01 via GF(2^8) division by x, one step per update.
//  Tracks the round index and flags the last round.
//  Emits rcon as a d-share constant sharing to the inverse key-schedule datapath.
//  Formal target: PINI at order d, flatten strategy; sh_rcon is a latency-0 sharing.
// PARAMETERS
//  d        2    number of shares
//  NROUNDS  10   AES-128 key-schedule rounds (index counts NROUNDS..1)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  start      in   1      pulse: load 0x36, begin sequence (honoured in IDLE only)
//  update     in   1      advance one round (honoured in RUN only)
//  mask_rcon  in   1      1: drive rcon on sh_rcon; 0: drive all-zero sharing
//  sh_rcon    out  8*d    shared rcon; share i = sh_rcon[8*i+:8]
//  round_idx  out  4      current round, NROUNDS..1 in RUN; 0 in IDLE
//  busy       out  1      high in RUN
//  last       out  1      high in RUN when round_idx==1 (rcon==0x01)
//  done       out  1      one-cycle pulse after the final update
// BEHAVIOUR
//  - Reset: state=IDLE, rcon=0x36, round_idx=0, busy=0, last=0, done=0.
//    sh_rcon = 0 while mask_rcon=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN: rcon<=0x36, round_idx<=NROUNDS.
//    RUN, update, round_idx>1: rcon<=inv_step(rcon), round_idx<=round_idx-1.
//    RUN, update, round_idx==1: state<=DONE, rcon<=0x36, round_idx<=0.
//    DONE --> IDLE unconditionally. done=1 only in DONE.
//  - inv_step(r) = (r==8'h1b) ? 8'h80 : r>>1.
//    Sequence: 36,1b,80,40,20,10,08,04,02,01.
//  - No update: rcon and round_idx hold.
//  - start in RUN or DONE: ignored. update in IDLE or DONE: ignored.
//  - start and update in the same IDLE cycle: start wins; update is dropped.
//  - rst mid-RUN: IDLE and reset values on the next edge; rst overrides start and update.
//  - Output path is combinational from registers (latency 0):
//    out = rcon & {8{mask_rcon}}; share0 = out; shares 1..d-1 = 0.
//    No randomness consumed; rcon is public.
// CONFIGURATION
//  MSKAES_INV_RCON_FWD_EN
//   defined: adds input dir_fwd (1 bit), sampled only on an accepted start.
//    - dir_fwd=1: load 0x01, step fwd_step(r) = r[7] ? 8'h1b : r<<1.
//    - Captured direction holds until DONE or rst.
//    - round_idx and last behave identically in both directions.
//   undefined: no dir_fwd port; inverse direction only.
// STRUCTURE
//  - Shared package mskaes_pkg:
//    RCON_FIRST=8'h01, RCON_LAST=8'h36, RCON_WRAP=8'h1b, AES128_NROUNDS=10.
//    FSM state typedef.
//  - Sharing through the existing constant-sharing cell MSKcst (d, count=8); no new sub-module.
//  - inv_step and fwd_step are local functions.
// TESTING
//  1. rst, then start, then 9 updates:
//     sh_rcon share0 = 36,1b,80,40,20,10,08,04,02,01; last=1 at 01.
//     10th update -> done pulse for 1 cycle, then IDLE with round_idx=0.
//  2. mask_rcon=0 in RUN at rcon=0x80: sh_rcon all zero.
//     Raise mask_rcon -> share0=0x80 in the same cycle; shares 1..d-1 always 0.
//  3. update held low 5 cycles at rcon=0x1b: rcon and round_idx hold; start pulses ignored.
//  4. rst asserted at round_idx=6 together with update:
//     IDLE, round_idx=0, rcon=0x36 next cycle, no done pulse.
//  5. start and update together in IDLE: RUN with rcon=0x36, round_idx=10 (update dropped).
//  6. FWD_EN build, dir_fwd=1: share0 = 01,02,04,08,10,20,40,80,1b,36; last at 36; done after 10th update.

Source files
------------

// File: rtl/mskaes_pkg.sv
// Shared constants and types for the masked AES key-schedule blocks.
//   RCON_FIRST / RCON_LAST : first (0x01) and last (0x36) AES-128 round constants
//   RCON_WRAP              : 0x1b, the reduction image of x^8 in GF(2^8)
//   AES128_NROUNDS         : number of AES-128 key-schedule rounds
//   rcon_state_e           : round-constant sequencer FSM state
package mskaes_pkg;

  localparam logic [7:0]  RCON_FIRST     = 8'h01;
  localparam logic [7:0]  RCON_LAST      = 8'h36;
  localparam logic [7:0]  RCON_WRAP      = 8'h1b;
  localparam int unsigned AES128_NROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rcon_state_e;

endpackage

// File: rtl/MSKcst.sv
// Constant-sharing cell: turns a public value into a d-share sharing.
// Share 0 carries the value, shares 1..d-1 are zero; no randomness consumed.
// Ports:
//   cst  in  count      public value
//   out  out count*d    sharing, share i = out[count*i +: count]
module MSKcst #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1
) (
  input  logic [count-1:0]   cst,
  output logic [count*d-1:0] out
);

  // Zero-extension places cst in share 0 and clears every other share.
  assign out = (count*d)'(cst);

endmodule

// File: rtl/mskaes_inv_rcon_seq.sv
// Masked AES-128 round-constant sequencer for the decryption key schedule.
// Walks rcon backward 0x36 -> 0x01 (division by x in GF(2^8)), one step per
// accepted update, tracking the round index and flagging the last round.
// rcon is public; it leaves as a latency-0 constant sharing.
// Optional build macro: MSKAES_INV_RCON_FWD_EN adds dir_fwd, selecting a
// forward walk 0x01 -> 0x36 when sampled high on an accepted start.
// Ports:
//   clk        in   1     clock
//   rst        in   1     synchronous active-high reset
//   start      in   1     load first rcon and enter RUN (IDLE only)
//   update     in   1     advance one round (RUN only)
//   mask_rcon  in   1     1: drive rcon on sh_rcon, 0: all-zero sharing
//   dir_fwd    in   1     (FWD_EN builds) forward direction, sampled on start
//   sh_rcon    out  8*d   shared rcon, share i = sh_rcon[8*i +: 8]
//   round_idx  out  4     NROUNDS..1 in RUN, 0 otherwise
//   busy       out  1     high in RUN
//   last       out  1     high in RUN at round_idx == 1
//   done       out  1     one-cycle pulse after the final update
module mskaes_inv_rcon_seq
  import mskaes_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned NROUNDS = AES128_NROUNDS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           update,
  input  logic           mask_rcon,
`ifdef MSKAES_INV_RCON_FWD_EN
  input  logic           dir_fwd,
`endif
  output logic [8*d-1:0] sh_rcon,
  output logic [3:0]     round_idx,
  output logic           busy,
  output logic           last,
  output logic           done
);

  // Division by x: 0x1b is the only reachable value whose division wraps.
  function automatic logic [7:0] inv_step(input logic [7:0] r);
    return (r == RCON_WRAP) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  // Multiplication by x with AES reduction.
  function automatic logic [7:0] fwd_step(input logic [7:0] r);
    return r[7] ? RCON_WRAP : {r[6:0], 1'b0};
  endfunction

  rcon_state_e r_state;
  rcon_state_e w_state_nxt;
  logic [7:0]  r_rcon;
  logic [7:0]  w_rcon_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  w_step;
  logic [7:0]  w_load;
  logic [7:0]  w_rcon_out;

`ifdef MSKAES_INV_RCON_FWD_EN
  logic        r_fwd;
  logic        w_fwd_nxt;
  assign w_step = r_fwd ? fwd_step(r_rcon) : inv_step(r_rcon);
  assign w_load = dir_fwd ? RCON_FIRST : RCON_LAST;
`else
  assign w_step = inv_step(r_rcon);
  assign w_load = RCON_LAST;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rcon  <= RCON_LAST;
      r_idx   <= 4'd0;
`ifdef MSKAES_INV_RCON_FWD_EN
      r_fwd   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rcon  <= w_rcon_nxt;
      r_idx   <= w_idx_nxt;
`ifdef MSKAES_INV_RCON_FWD_EN
      r_fwd   <= w_fwd_nxt;
`endif
    end
  end

  // Next-state and next-datapath logic; start wins over update in IDLE
  // simply because update is not looked at there.
  always_comb begin
    w_state_nxt = r_state;
    w_rcon_nxt  = r_rcon;
    w_idx_nxt   = r_idx;
`ifdef MSKAES_INV_RCON_FWD_EN
    w_fwd_nxt   = r_fwd;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_rcon_nxt  = w_load;
          w_idx_nxt   = 4'(NROUNDS);
`ifdef MSKAES_INV_RCON_FWD_EN
          w_fwd_nxt   = dir_fwd;
`endif
        end
      end
      ST_RUN: begin
        if (update) begin
          if (r_idx == 4'd1) begin
            w_state_nxt = ST_DONE;
            w_rcon_nxt  = RCON_LAST;
            w_idx_nxt   = 4'd0;
`ifdef MSKAES_INV_RCON_FWD_EN
            w_fwd_nxt   = 1'b0;
`endif
          end else begin
            w_rcon_nxt  = w_step;
            w_idx_nxt   = r_idx - 4'd1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy      = (r_state == ST_RUN);
    last      = (r_state == ST_RUN) && (r_idx == 4'd1);
    done      = (r_state == ST_DONE);
    round_idx = r_idx;
  end

  // Latency-0 output: gate with mask_rcon, then share as a public constant.
  assign w_rcon_out = r_rcon & {8{mask_rcon}};

  MSKcst #(
    .d     (d),
    .count (8)
  ) u_cst (
    .cst (w_rcon_out),
    .out (sh_rcon)
  );

endmodule

// File: tb/tb_mskaes_inv_rcon_seq.sv
module tb_mskaes_inv_rcon_seq;

  localparam int unsigned D = 2;

  typedef struct {
    logic       rst;
    logic       start;
    logic       update;
    logic       mask;
    logic       fwd;
    logic [7:0] sh0;
    logic [3:0] idx;
    logic       busy;
    logic       last;
    logic       done;
  } vec_t;

  typedef struct {
    logic [7:0] sh0;
    logic [3:0] idx;
    logic       busy;
    logic       last;
    logic       done;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           update;
  logic           mask_rcon;
  logic           dir_fwd;
  logic [8*D-1:0] sh_rcon;
  logic [3:0]     round_idx;
  logic           busy;
  logic           last;
  logic           done;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mskaes_inv_rcon_seq #(.d(D), .NROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .update    (update),
    .mask_rcon (mask_rcon),
`ifdef MSKAES_INV_RCON_FWD_EN
    .dir_fwd   (dir_fwd),
`endif
    .sh_rcon   (sh_rcon),
    .round_idx (round_idx),
    .busy      (busy),
    .last      (last),
    .done      (done)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic u,
                               input logic m, input logic f, input logic [7:0] sh0,
                               input logic [3:0] idx, input logic b,
                               input logic l, input logic dn);
    vec_t v;
    v.rst = r; v.start = s; v.update = u; v.mask = m; v.fwd = f;
    v.sh0 = sh0; v.idx = idx; v.busy = b; v.last = l; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_now(input string tag, input exp_t e);
    logic [7:0] upper;
    upper = 8'(sh_rcon >> 8);
    chk({tag, ".sh0"},   32'(sh_rcon[7:0]), 32'(e.sh0));
    chk({tag, ".sh1"},   32'(upper),        32'd0);
    chk({tag, ".idx"},   32'(round_idx),    32'(e.idx));
    chk({tag, ".busy"},  32'(busy),         32'(e.busy));
    chk({tag, ".last"},  32'(last),         32'(e.last));
    chk({tag, ".done"},  32'(done),         32'(e.done));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; start = v.start; update = v.update;
    mask_rcon = v.mask; dir_fwd = v.fwd;
    e.sh0 = v.sh0; e.idx = v.idx; e.busy = v.busy; e.last = v.last; e.done = v.done;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s.scoreboard: queue empty", tag);
    end else begin
      check_now(tag, sb_q.pop_front());
    end
  endtask

  task automatic do_reset();
    run_vec("rst", mk(1, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    exp_t e;
    logic [7:0] fseq[10];

    rst = 1'b1; start = 1'b0; update = 1'b0; mask_rcon = 1'b0; dir_fwd = 1'b0;

    // Test 1: full inverse walk (reset state with mask low gives a zero sharing)
    tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 4'd0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 8'h36, 4'd0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 0, 8'h36, 4'd10, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 0, 8'h1b, 4'd9,  1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 0, 8'h80, 4'd8,  1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 8'h40, 4'd7,  1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 8'h20, 4'd6,  1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 8'h10, 4'd5,  1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 0, 8'h08, 4'd4,  1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 8'h04, 4'd3,  1, 0, 0);
    tbl[10] = mk(0, 0, 1, 1, 0, 8'h02, 4'd2,  1, 0, 0);
    tbl[11] = mk(0, 0, 1, 1, 0, 8'h01, 4'd1,  1, 1, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 8'h36, 4'd0,  0, 0, 1);
    for (int i = 0; i < 13; i++) run_vec($sformatf("t1[%0d]", i), tbl[i]);
    run_vec("t1.idle", mk(0, 0, 0, 1, 0, 8'h36, 4'd0, 0, 0, 0));
    run_vec("t1.idle2", mk(0, 0, 1, 1, 0, 8'h36, 4'd0, 0, 0, 0));

    // Test 2: mask gating at rcon 0x80, mask raised without a clock edge
    do_reset();
    run_vec("t2.start", mk(0, 1, 0, 1, 0, 8'h36, 4'd10, 1, 0, 0));
    run_vec("t2.u1",    mk(0, 0, 1, 1, 0, 8'h1b, 4'd9,  1, 0, 0));
    run_vec("t2.u2",    mk(0, 0, 1, 0, 0, 8'h00, 4'd8,  1, 0, 0));
    run_vec("t2.hold",  mk(0, 0, 0, 0, 0, 8'h00, 4'd8,  1, 0, 0));
    @(negedge clk);
    mask_rcon = 1'b1;
    #1;
    e.sh0 = 8'h80; e.idx = 4'd8; e.busy = 1'b1; e.last = 1'b0; e.done = 1'b0;
    check_now("t2.unmask", e);

    // Test 3: hold at 0x1b for 5 cycles with start pulses ignored
    do_reset();
    run_vec("t3.start", mk(0, 1, 0, 1, 0, 8'h36, 4'd10, 1, 0, 0));
    run_vec("t3.u1",    mk(0, 0, 1, 1, 0, 8'h1b, 4'd9,  1, 0, 0));
    for (int i = 0; i < 5; i++)
      run_vec($sformatf("t3.hold[%0d]", i),
              mk(0, (i % 2 == 0), 0, 1, 0, 8'h1b, 4'd9, 1, 0, 0));
    run_vec("t3.u2",    mk(0, 1, 1, 1, 0, 8'h80, 4'd8,  1, 0, 0));

    // Test 4: reset together with update at round 6
    do_reset();
    run_vec("t4.start", mk(0, 1, 0, 1, 0, 8'h36, 4'd10, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r4[4];
      r4[0] = 8'h1b; r4[1] = 8'h80; r4[2] = 8'h40; r4[3] = 8'h20;
      run_vec($sformatf("t4.u[%0d]", i), mk(0, 0, 1, 1, 0, r4[i], 4'(9 - i), 1, 0, 0));
    end
    run_vec("t4.rst",   mk(1, 1, 1, 1, 0, 8'h36, 4'd0, 0, 0, 0));
    run_vec("t4.after", mk(0, 0, 1, 1, 0, 8'h36, 4'd0, 0, 0, 0));

    // Test 5: start and update together in IDLE; update is dropped
    run_vec("t5.both",  mk(0, 1, 1, 1, 0, 8'h36, 4'd10, 1, 0, 0));
    run_vec("t5.u1",    mk(0, 0, 1, 1, 0, 8'h1b, 4'd9,  1, 0, 0));

`ifdef MSKAES_INV_RCON_FWD_EN
    // Test 6: forward walk, then an inverse start after DONE
    do_reset();
    fseq[0] = 8'h01; fseq[1] = 8'h02; fseq[2] = 8'h04; fseq[3] = 8'h08; fseq[4] = 8'h10;
    fseq[5] = 8'h20; fseq[6] = 8'h40; fseq[7] = 8'h80; fseq[8] = 8'h1b; fseq[9] = 8'h36;
    run_vec("t6.start", mk(0, 1, 0, 1, 1, fseq[0], 4'd10, 1, 0, 0));
    for (int i = 1; i < 10; i++)
      run_vec($sformatf("t6.u[%0d]", i),
              mk(0, 0, 1, 1, 0, fseq[i], 4'(10 - i), 1, (i == 9), 0));
    run_vec("t6.done",  mk(0, 0, 1, 1, 0, 8'h36, 4'd0, 0, 0, 1));
    run_vec("t6.idle",  mk(0, 0, 0, 1, 0, 8'h36, 4'd0, 0, 0, 0));
    run_vec("t6.inv",   mk(0, 1, 0, 1, 0, 8'h36, 4'd10, 1, 0, 0));
    run_vec("t6.inv1",  mk(0, 0, 1, 1, 1, 8'h1b, 4'd9,  1, 0, 0));
`else
    fseq[0] = 8'h00;
`endif

    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard.drain: %0d entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
